// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: RV32I funct3 size codes,
// FSM state encoding and byte-lane helpers.
package dmem_responder_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    function automatic logic size_legal(input logic [2:0] size);
        return (size == SZ_B) || (size == SZ_H) || (size == SZ_W) ||
               (size == SZ_BU) || (size == SZ_HU);
    endfunction

    function automatic logic size_misaligned(input logic [2:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            SZ_H, SZ_HU: bad = lo[0];
            SZ_W:        bad = (lo != 2'b00);
            default:     bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Byte enables of the lanes touched by an access of the given size and offset.
    function automatic logic [3:0] lane_be(input logic [2:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            SZ_B, SZ_BU: be = 4'b0001 << lo;
            SZ_H, SZ_HU: be = lo[1] ? 4'b1100 : 4'b0011;
            SZ_W:        be = 4'b1111;
            default:     be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the core's data port (master) and the memory responder (slave).
interface dmem_responder_if #(
    parameter int AW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [2:0]    req_size;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lane_array.sv
// Word-organised storage split into four byte lanes: one synchronous write port
// with per-lane enables and a combinational read port sharing the word index.
module dmem_lane_array #(
    parameter int DEPTH = 1024,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [3:0]    wr_be,
    input  logic [IW-1:0] idx,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (wr_en && wr_be[gi]) begin
                    lane_mem[idx] <= wr_data[8*gi +: 8];
                end
            end

            assign rd_data[8*gi +: 8] = lane_mem[idx];
        end
    endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, inserts WAIT_CYCLES
// wait states, checks size/alignment/range, and returns an extended load result.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int AW          = 32
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);

    localparam int          IW         = $clog2(DEPTH);
    localparam logic [AW:0] ADDR_LIMIT = (AW+1)'(DEPTH * 4);
    localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES);

    state_t        state_reg;
    logic [3:0]    cnt_reg;
    logic          we_reg;
    logic [AW-1:0] addr_reg;
    logic [2:0]    size_reg;
    logic [31:0]   wdata_reg;
    logic          req_ready_reg;
    logic          rsp_valid_reg;
    logic [31:0]   rsp_rdata_reg;
    logic          rsp_err_reg;

    logic          acc_err;
    logic          exec;
    logic          wr_en;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;
    logic [31:0]   rd_word;
    logic [31:0]   rd_shift;
    logic [15:0]   rd_half;
    logic [31:0]   load_data;
    logic [31:0]   rsp_value;
    logic [IW-1:0] word_idx;

    assign word_idx = addr_reg[IW+1:2];

    always_comb begin
        acc_err = !size_legal(size_reg) ||
                  size_misaligned(size_reg, addr_reg[1:0]) ||
                  ({1'b0, addr_reg} >= ADDR_LIMIT) ||
                  (we_reg && size_reg[2]);
    end

    // The access executes on the edge that leaves WAIT with an exhausted counter,
    // giving a response WAIT_CYCLES+1 edges after the accept edge.
    assign exec  = (state_reg == ST_WAIT) && (cnt_reg == 4'd0);
    // Gate with rst so a reset landing on the execute edge aborts the store.
    assign wr_en = rst && exec && we_reg && !acc_err;
    assign wr_be = lane_be(size_reg, addr_reg[1:0]);

    always_comb begin
        case (size_reg)
            SZ_B:    wr_data = {4{wdata_reg[7:0]}};
            SZ_H:    wr_data = {2{wdata_reg[15:0]}};
            default: wr_data = wdata_reg;
        endcase
    end

    dmem_lane_array #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_lanes (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_be   (wr_be),
        .idx     (word_idx),
        .wr_data (wr_data),
        .rd_data (rd_word)
    );

    always_comb begin
        rd_shift = rd_word >> {addr_reg[1:0], 3'b000};
        rd_half  = addr_reg[1] ? rd_word[31:16] : rd_word[15:0];
        case (size_reg)
            SZ_B:    load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            SZ_BU:   load_data = {24'd0, rd_shift[7:0]};
            SZ_H:    load_data = {{16{rd_half[15]}}, rd_half};
            SZ_HU:   load_data = {16'd0, rd_half};
            SZ_W:    load_data = rd_word;
            default: load_data = 32'd0;
        endcase
        rsp_value = (acc_err || we_reg) ? 32'd0 : load_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 4'd0;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 32'd0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    req_ready_reg <= 1'b1;
                    if (bus.req_valid && req_ready_reg) begin
                        we_reg        <= bus.req_we;
                        addr_reg      <= bus.req_addr;
                        size_reg      <= bus.req_size;
                        wdata_reg     <= bus.req_wdata;
                        req_ready_reg <= 1'b0;
                        cnt_reg       <= WAIT_INIT;
                        state_reg     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        rsp_valid_reg <= 1'b1;
                        rsp_rdata_reg <= rsp_value;
                        rsp_err_reg   <= acc_err;
                        state_reg     <= ST_RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        rsp_rdata_reg <= 32'd0;
                        rsp_err_reg   <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.rsp_err   = rsp_err_reg;

endmodule
